// File: rtl/br_port_master.sv
// Initiator for the 32x32 register bank: zero-fills the bank after reset, then
// issues pipelined operand reads and writebacks with write-to-read bypass.
module br_port_master #(
  parameter int NREG          = 32,
  parameter int ABITS         = 5,
  parameter int DW            = 32,
  parameter int ZERO_REG_RO   = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [ABITS-1:0] rs_addr,
  input  logic [ABITS-1:0] rt_addr,
  output logic             op_valid,
  output logic [DW-1:0]    op_a,
  output logic [DW-1:0]    op_b,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [ABITS-1:0] wr_addr,
  input  logic [DW-1:0]    wr_data,
  output logic             br_we,
  output logic [ABITS-1:0] br_ar1,
  output logic [ABITS-1:0] br_ar2,
  output logic [ABITS-1:0] br_aw,
  output logic [DW-1:0]    br_din,
  input  logic [DW-1:0]    br_dr1,
  input  logic [DW-1:0]    br_dr2,
  output logic             init_done
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [ABITS-1:0] LAST_REG    = ABITS'(NREG - 1);
  localparam state_t           RESET_STATE = (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
  localparam logic             RESET_DONE  = (INIT_ON_RESET == 0);

  state_t           state, state_nxt;
  logic [ABITS-1:0] cnt, cnt_nxt;
  logic             rd_pend, rd_pend_nxt;

  logic             rd_acc, wr_acc, wr_drop;
  logic             rdy_nxt, done_nxt, we_nxt, opv_nxt;
  logic [ABITS-1:0] aw_nxt, ar1_nxt, ar2_nxt;
  logic [DW-1:0]    din_nxt, opa_nxt, opb_nxt;
  logic [DW-1:0]    cap_a, cap_b;

  assign rd_acc  = rd_valid && rd_ready;
  assign wr_acc  = wr_valid && wr_ready;
  assign wr_drop = (ZERO_REG_RO != 0) && (wr_addr == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == S_INIT) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == LAST_REG) begin
        state_nxt = S_RUN;
      end
    end
  end

  // Operand capture: register 0 reads as zero, otherwise a write on the bus
  // this cycle to the same address overrides the bank's stale read data.
  always_comb begin
    cap_a = br_dr1;
    cap_b = br_dr2;
    if ((ZERO_REG_RO != 0) && (br_ar1 == '0)) begin
      cap_a = '0;
    end else if (br_we && (br_aw == br_ar1)) begin
      cap_a = br_din;
    end
    if ((ZERO_REG_RO != 0) && (br_ar2 == '0)) begin
      cap_b = '0;
    end else if (br_we && (br_aw == br_ar2)) begin
      cap_b = br_din;
    end
  end

  always_comb begin
    rdy_nxt     = (state == S_RUN);
    done_nxt    = init_done || (state == S_RUN);
    we_nxt      = 1'b0;
    aw_nxt      = br_aw;
    din_nxt     = br_din;
    ar1_nxt     = br_ar1;
    ar2_nxt     = br_ar2;
    rd_pend_nxt = 1'b0;
    opv_nxt     = 1'b0;
    opa_nxt     = op_a;
    opb_nxt     = op_b;

    case (state)
      S_INIT: begin
        we_nxt  = 1'b1;
        aw_nxt  = cnt;
        din_nxt = '0;
      end
      S_RUN: begin
        if (wr_acc && !wr_drop) begin
          we_nxt  = 1'b1;
          aw_nxt  = wr_addr;
          din_nxt = wr_data;
        end
        if (rd_acc) begin
          ar1_nxt     = rs_addr;
          ar2_nxt     = rt_addr;
          rd_pend_nxt = 1'b1;
        end
      end
      default: begin
        we_nxt = 1'b0;
      end
    endcase

    if (rd_pend) begin
      opv_nxt = 1'b1;
      opa_nxt = cap_a;
      opb_nxt = cap_b;
    end
  end

  // Every port output is a flop; reset flushes the read/write pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ready  <= 1'b0;
      wr_ready  <= 1'b0;
      init_done <= RESET_DONE;
      br_we     <= 1'b0;
      br_aw     <= '0;
      br_din    <= '0;
      br_ar1    <= '0;
      br_ar2    <= '0;
      rd_pend   <= 1'b0;
      op_valid  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
    end else begin
      rd_ready  <= rdy_nxt;
      wr_ready  <= rdy_nxt;
      init_done <= done_nxt;
      br_we     <= we_nxt;
      br_aw     <= aw_nxt;
      br_din    <= din_nxt;
      br_ar1    <= ar1_nxt;
      br_ar2    <= ar2_nxt;
      rd_pend   <= rd_pend_nxt;
      op_valid  <= opv_nxt;
      op_a      <= opa_nxt;
      op_b      <= opb_nxt;
    end
  end

endmodule

// File: tb/tb_br_port_master.sv
// Directed bench for br_port_master with a behavioural 32x32 register bank.
module tb_br_port_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_valid, rd_ready, wr_valid, wr_ready;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic        op_valid;
  logic [31:0] op_a, op_b, wr_data;
  logic        br_we;
  logic [4:0]  br_ar1, br_ar2, br_aw;
  logic [31:0] br_din, br_dr1, br_dr2;
  logic        init_done;

  logic [31:0] bank [32];
  int vec_count  = 0;
  int miss_count = 0;

  typedef struct {
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        exp_we;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  br_port_master dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .br_we(br_we), .br_ar1(br_ar1), .br_ar2(br_ar2),
    .br_aw(br_aw), .br_din(br_din),
    .br_dr1(br_dr1), .br_dr2(br_dr2),
    .init_done(init_done)
  );

  // Bank starts with junk so the zero-fill is observable.
  initial begin
    for (int i = 0; i < 32; i++) bank[i] = 32'hA5A5_0000 + 32'(i);
    forever begin
      @(posedge clk);
      if (br_we) bank[br_aw] <= br_din;
    end
  end

  assign br_dr1 = bank[br_ar1];
  assign br_dr2 = bank[br_ar2];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(logic wr, logic [4:0] wa, logic [31:0] wd, logic rd,
                              logic [4:0] rs, logic [4:0] rt, logic we,
                              logic [31:0] a, logic [31:0] b);
    vec_t v;
    v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.rs = rs; v.rt = rt;
    v.exp_we = we; v.exp_a = a; v.exp_b = b;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkBankZero(input string tag);
    int nz = 0;
    for (int i = 0; i < 32; i++) if (bank[i] !== 32'h0) nz++;
    checkOutput({tag, "_bank_nonzero"}, 32'(nz), 32'd0);
  endtask

  // Caller releases reset just after an edge; the next 32 edges each show one fill write.
  task automatic runZeroFill(input string tag);
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("%s_we_%0d", tag, k), 32'(br_we), 32'd1);
      checkOutput($sformatf("%s_aw_%0d", tag, k), 32'(br_aw), 32'(k));
      checkOutput($sformatf("%s_din_%0d", tag, k), br_din, 32'd0);
      checkOutput($sformatf("%s_done_%0d", tag, k), 32'(init_done), 32'd0);
    end
    @(posedge clk); #1;
    checkOutput({tag, "_we_end"}, 32'(br_we), 32'd0);
    checkOutput({tag, "_done_end"}, 32'(init_done), 32'd1);
    checkOutput({tag, "_rd_ready"}, 32'(rd_ready), 32'd1);
    checkOutput({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    checkBankZero(tag);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    rd_valid = v.rd; rs_addr = v.rs; rt_addr = v.rt;
    wr_valid = v.wr; wr_addr = v.wa; wr_data = v.wd;
    @(posedge clk); #1;
    rd_valid = 1'b0; wr_valid = 1'b0;
    checkOutput($sformatf("v%0d_we", idx), 32'(br_we), 32'(v.exp_we));
    if (v.exp_we) begin
      checkOutput($sformatf("v%0d_aw", idx), 32'(br_aw), 32'(v.wa));
      checkOutput($sformatf("v%0d_din", idx), br_din, v.wd);
    end
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d_opv", idx), 32'(op_valid), 32'(v.rd));
    if (v.rd) begin
      checkOutput($sformatf("v%0d_op_a", idx), op_a, v.exp_a);
      checkOutput($sformatf("v%0d_op_b", idx), op_b, v.exp_b);
    end
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d_we_pulse", idx), 32'(br_we), 32'd0);
    checkOutput($sformatf("v%0d_opv_pulse", idx), 32'(op_valid), 32'd0);
  endtask

  initial begin
    //               wr  wa  wd            rd  rs  rt  we  exp_a         exp_b
    vecs[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0,  1, 32'h0,        32'h0);
    vecs[1]  = mk(0, 0,  32'h0,        1, 5,  0,  0, 32'hDEADBEEF, 32'h0);
    vecs[2]  = mk(1, 7,  32'h12345678, 1, 7,  7,  1, 32'h12345678, 32'h12345678);
    vecs[3]  = mk(1, 0,  32'hFFFFFFFF, 0, 0,  0,  0, 32'h0,        32'h0);
    vecs[4]  = mk(0, 0,  32'h0,        1, 0,  0,  0, 32'h0,        32'h0);
    vecs[5]  = mk(1, 1,  32'd1,        0, 0,  0,  1, 32'h0,        32'h0);
    vecs[6]  = mk(1, 2,  32'd2,        0, 0,  0,  1, 32'h0,        32'h0);
    vecs[7]  = mk(1, 3,  32'd3,        0, 0,  0,  1, 32'h0,        32'h0);
    vecs[8]  = mk(1, 4,  32'd4,        0, 0,  0,  1, 32'h0,        32'h0);
    vecs[9]  = mk(1, 9,  32'hCAFEF00D, 1, 9,  5,  1, 32'hCAFEF00D, 32'hDEADBEEF);
    vecs[10] = mk(0, 0,  32'h0,        1, 5,  9,  0, 32'hDEADBEEF, 32'hCAFEF00D);
    vecs[11] = mk(1, 31, 32'h80000001, 1, 0,  31, 1, 32'h0,        32'h80000001);
    vecs[12] = mk(1, 0,  32'h11111111, 1, 0,  0,  0, 32'h0,        32'h0);

    rst = 1'b1; rd_valid = 1'b0; wr_valid = 1'b0;
    rs_addr = '0; rt_addr = '0; wr_addr = '0; wr_data = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_we", 32'(br_we), 32'd0);
    checkOutput("rst_opv", 32'(op_valid), 32'd0);
    checkOutput("rst_done", 32'(init_done), 32'd0);
    checkOutput("rst_rd_ready", 32'(rd_ready), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
    rst = 1'b0;
    runZeroFill("init");

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i], i);

    // Four back-to-back reads of r1..r4 give four consecutive OP_VALID pulses.
    for (int c = 0; c < 6; c++) begin
      rd_valid = (c < 4);
      rs_addr  = 5'(c + 1);
      rt_addr  = 5'(4 - c);
      @(posedge clk); #1;
      checkOutput($sformatf("b2b_opv_%0d", c), 32'(op_valid), 32'((c >= 1) && (c <= 4)));
      if ((c >= 1) && (c <= 4)) begin
        checkOutput($sformatf("b2b_op_a_%0d", c), op_a, 32'(c));
        checkOutput($sformatf("b2b_op_b_%0d", c), op_b, 32'(5 - c));
      end
    end
    rd_valid = 1'b0;

    // Reset in the middle of the zero-fill restarts it from address 0.
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst2_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("mid_aw", 32'(br_aw), 32'd9);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid_rst_we", 32'(br_we), 32'd0);
    checkOutput("mid_rst_aw", 32'(br_aw), 32'd0);
    rst = 1'b0;
    runZeroFill("refill");

    // Reset with a read and a write in flight: no OP_VALID, WE dropped, fill restarts.
    rd_valid = 1'b1; rs_addr = 5'd12; rt_addr = 5'd3;
    wr_valid = 1'b1; wr_addr = 5'd12; wr_data = 32'h5555AAAA;
    @(posedge clk); #1;
    rd_valid = 1'b0; wr_valid = 1'b0;
    checkOutput("fly_we", 32'(br_we), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("fly_rst_opv", 32'(op_valid), 32'd0);
    checkOutput("fly_rst_we", 32'(br_we), 32'd0);
    @(posedge clk); #1;
    checkOutput("fly_rst_opv2", 32'(op_valid), 32'd0);
    checkOutput("fly_rst_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    runZeroFill("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
